// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared encodings and helpers for the EX-stage divider
package div_unit_pkg;

   localparam int DATA_BUS      = 32;
   localparam int DIV_ITER_LAST = 31;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ZERO = 2'd1,
      DIV_BUSY = 2'd2,
      DIV_DONE = 2'd3
   } div_state_t;

   // Two's-complement magnitude, applied only for signed operations.
   function automatic logic [DATA_BUS-1:0] div_mag(input logic [DATA_BUS-1:0] v,
                                                   input logic                is_signed);
      return (is_signed && v[DATA_BUS-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational restoring-division iteration
module div_unit_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_rem,
   input  logic [W-1:0] i_dvd,
   input  logic [W-1:0] i_dsr,
   output logic [W-1:0] o_rem,
   output logic [W-1:0] o_dvd,
   output logic         o_q_bit
);

   logic [W:0]   w_shifted;
   logic [W-1:0] w_trial;

   // Shift the next dividend bit into the partial remainder, then try subtracting.
   // When the subtraction is kept the true difference is below the divisor, so a
   // W-bit result is exact; the compare decides using the full W+1-bit value.
   always_comb begin
      w_shifted = {i_rem, i_dvd[W-1]};
      w_trial   = w_shifted[W-1:0] - i_dsr;
      o_q_bit   = (w_shifted >= {1'b0, i_dsr});
      o_rem     = o_q_bit ? w_trial : w_shifted[W-1:0];
      o_dvd     = {i_dvd[W-2:0], 1'b0};
   end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit DIV/DIVU producing LO=quotient, HI=remainder
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_BUS,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  start,
   input  logic                  signed_div,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  stall_request,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);

   div_state_t            r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [DATA_WIDTH-1:0] r_dvd;
   logic [DATA_WIDTH-1:0] r_dsr;
   logic                  r_q_neg;
   logic                  r_r_neg;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_quotient;
   logic [DATA_WIDTH-1:0] r_remainder;

   logic [DATA_WIDTH-1:0] w_rem_nxt;
   logic [DATA_WIDTH-1:0] w_dvd_shift;
   logic [DATA_WIDTH-1:0] w_quot_nxt;
   logic                  w_q_bit;

   div_unit_step #(.W(DATA_WIDTH)) u_step (
      .i_rem   (r_rem),
      .i_dvd   (r_dvd),
      .i_dsr   (r_dsr),
      .o_rem   (w_rem_nxt),
      .o_dvd   (w_dvd_shift),
      .o_q_bit (w_q_bit)
   );

   // Quotient bits accumulate in the vacated low end of the dividend register.
   assign w_quot_nxt = w_dvd_shift | {{(DATA_WIDTH-1){1'b0}}, w_q_bit};

   assign stall_request = start & ~r_done & ~flush & ~rst;
   assign done          = r_done;
   assign quotient      = r_quotient;
   assign remainder     = r_remainder;

   // Divider control FSM with registered result and done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= DIV_IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_dvd       <= '0;
         r_dsr       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else if (flush) begin
         // Abort without touching the last result so no HI/LO write appears.
         r_state <= DIV_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     // Raw dividend is kept for the remainder of a divide-by-zero.
                     r_dvd   <= dividend;
                     r_state <= DIV_ZERO;
                  end else begin
                     r_dvd   <= div_mag(dividend, signed_div);
                     r_dsr   <= div_mag(divisor, signed_div);
                     r_q_neg <= signed_div & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                     r_r_neg <= signed_div & dividend[DATA_WIDTH-1];
                     r_cnt   <= '0;
                     r_rem   <= '0;
                     r_state <= DIV_BUSY;
                  end
               end
            end
            DIV_ZERO: begin
               r_quotient  <= '1;
               r_remainder <= r_dvd;
               r_done      <= 1'b1;
               r_state     <= DIV_DONE;
            end
            DIV_BUSY: begin
               r_rem <= w_rem_nxt;
               r_dvd <= w_quot_nxt;
               r_cnt <= r_cnt + CNT_WIDTH'(1);
               if (r_cnt == CNT_WIDTH'(DIV_ITER_LAST)) begin
                  r_quotient  <= r_q_neg ? (~w_quot_nxt + 1'b1) : w_quot_nxt;
                  r_remainder <= r_r_neg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
                  r_done      <= 1'b1;
                  r_state     <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               if (!start) begin
                  r_done  <= 1'b0;
                  r_state <= DIV_IDLE;
               end
            end
            default: r_state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        start;
   logic        signed_div;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        stall_request;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int n_tests;
   int n_fail;

   div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .start         (start),
      .signed_div    (signed_div),
      .dividend      (dividend),
      .divisor       (divisor),
      .stall_request (stall_request),
      .done          (done),
      .quotient      (quotient),
      .remainder     (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raise start for one operation and wait for done; lat is the cycle index
   // (start-first-high = 0) where done appears, -1 on timeout. sbad counts
   // cycles where stall_request disagreed with "high until done".
   task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int sbad);
      lat  = -1;
      sbad = 0;
      @(posedge clk); #1;
      start = 1'b1; signed_div = sd; dividend = a; divisor = b;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (stall_request !== 1'b0) sbad++;
            lat = c;
            break;
         end
         if (stall_request !== 1'b1) sbad++;
         @(posedge clk); #1;
      end
   endtask

   task automatic release_start();
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; signed_div = 1'b0; dividend = 32'd9; divisor = 32'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_tests++;
      if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_q got=%h exp=0", quotient); end
      n_tests++;
      if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_r got=%h exp=0", remainder); end
      n_tests++;
      if (stall_request !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_request); end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned_basic();
      int lat, sbad;
      do_div(1'b0, 32'd100, 32'd7, lat, sbad);
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got=%0d exp=33", lat); end
      n_tests++;
      if (quotient !== 32'd14) begin n_fail++; $display("FAIL divu_q got=%0d exp=14", quotient); end
      n_tests++;
      if (remainder !== 32'd2) begin n_fail++; $display("FAIL divu_r got=%0d exp=2", remainder); end
      n_tests++;
      if (sbad !== 0) begin n_fail++; $display("FAIL divu_stall bad_cycles=%0d exp=0", sbad); end
      release_start();
   endtask

   // Signed quadrants and corner values, one row per operation.
   task automatic test_vectors();
      logic        v_sd [7];
      logic [31:0] v_a  [7];
      logic [31:0] v_b  [7];
      logic [31:0] v_q  [7];
      logic [31:0] v_r  [7];
      int lat, sbad;
      v_sd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      v_a  = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFF9};
      v_b  = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd9, 32'd2};
      v_q  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFC};
      v_r  = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd5, 32'd1};
      for (int i = 0; i < 7; i++) begin
         do_div(v_sd[i], v_a[i], v_b[i], lat, sbad);
         n_tests++;
         if (lat !== 33 || sbad !== 0) begin
            n_fail++; $display("FAIL vec%0d_timing lat=%0d exp=33 stall_bad=%0d", i, lat, sbad);
         end
         n_tests++;
         if (quotient !== v_q[i]) begin n_fail++; $display("FAIL vec%0d_q got=%h exp=%h", i, quotient, v_q[i]); end
         n_tests++;
         if (remainder !== v_r[i]) begin n_fail++; $display("FAIL vec%0d_r got=%h exp=%h", i, remainder, v_r[i]); end
         release_start();
      end
   endtask

   task automatic test_div_zero();
      int lat, sbad;
      do_div(1'b1, 32'd1234, 32'd0, lat, sbad);
      n_tests++;
      if (lat !== 2 || sbad !== 0) begin n_fail++; $display("FAIL divzero_timing lat=%0d exp=2 stall_bad=%0d", lat, sbad); end
      n_tests++;
      if (quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divzero_q got=%h exp=ffffffff", quotient); end
      n_tests++;
      if (remainder !== 32'd1234) begin n_fail++; $display("FAIL divzero_r got=%0d exp=1234", remainder); end
      release_start();
   endtask

   // Runs right after the divide-by-zero, so the prior result is FFFFFFFF / 1234.
   task automatic test_flush();
      int lat, sbad;
      @(posedge clk); #1;
      start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      n_tests++;
      if (stall_request !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall_request); end
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done got=%b exp=0", done); end
      n_tests++;
      if (quotient !== 32'hFFFFFFFF || remainder !== 32'd1234) begin
         n_fail++; $display("FAIL flush_keep q=%h r=%h exp q=ffffffff r=000004d2", quotient, remainder);
      end
      do_div(1'b0, 32'd100, 32'd7, lat, sbad);
      n_tests++;
      if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
         n_fail++; $display("FAIL flush_rerun lat=%0d q=%0d r=%0d exp lat=33 q=14 r=2", lat, quotient, remainder);
      end
      release_start();
   endtask

   task automatic test_hold_start();
      int lat, sbad, bad;
      bad = 0;
      do_div(1'b0, 32'd100, 32'd7, lat, sbad);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2 || stall_request !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL drop_start_done got=%b exp=0", done); end
      n_tests++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         n_fail++; $display("FAIL drop_start_keep q=%0d r=%0d exp q=14 r=2", quotient, remainder);
      end
   endtask

   task automatic test_operand_change();
      int lat;
      lat = -1;
      @(posedge clk); #1;
      start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      repeat (5) @(posedge clk);
      #1 signed_div = 1'b1; dividend = 32'hFFFFFF00; divisor = 32'd0;
      for (int c = 5; c < 100; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = c; break; end
         @(posedge clk); #1;
      end
      n_tests++;
      if (lat !== 33) begin n_fail++; $display("FAIL opchg_latency got=%0d exp=33", lat); end
      n_tests++;
      if (quotient !== 32'd333 || remainder !== 32'd1) begin
         n_fail++; $display("FAIL opchg_result q=%0d r=%0d exp q=333 r=1", quotient, remainder);
      end
      release_start();
   endtask

   task automatic test_reset_busy();
      int lat, sbad;
      @(posedge clk); #1;
      start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd6;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || stall_request !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy done=%b q=%h r=%h stall=%b exp all 0", done, quotient, remainder, stall_request);
      end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      do_div(1'b0, 32'd50, 32'd6, lat, sbad);
      n_tests++;
      if (lat !== 33 || sbad !== 0 || quotient !== 32'd8 || remainder !== 32'd2) begin
         n_fail++; $display("FAIL rst_rerun lat=%0d stall_bad=%0d q=%0d r=%0d exp lat=33 q=8 r=2", lat, sbad, quotient, remainder);
      end
      release_start();
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b1; flush = 1'b0; start = 1'b0; signed_div = 1'b0;
      dividend = '0; divisor = '0;
      test_reset();
      test_unsigned_basic();
      test_vectors();
      test_div_zero();
      test_flush();
      test_hold_start();
      test_operand_change();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
